// File: rtl/conv2d_mac_seq_pkg.sv
// Shared types and helpers for the convolution MAC and the pooling block.
// This includes the state encoding, the sizing functions and the round/saturate helper.
package conv_pkg;
  localparam int ACC_MAX = 128;
  localparam int RES_MAX = 64;

  typedef enum logic [1:0] {IDLE, MAC, ROUND, OUT} conv_state_t;

  typedef struct packed {
    logic                      sat;
    logic signed [RES_MAX-1:0] val;
  } sat_res_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // Round half up, arithmetic shift, then clip to a signed dw-bit range.
  function automatic sat_res_t sat_round(input logic signed [ACC_MAX-1:0] acc,
                                         input int dw, input int frac);
    logic signed [ACC_MAX-1:0] one, half, r, hi, lo;
    sat_res_t res;
    one = ACC_MAX'(1);
    r   = acc;
    if (frac > 0) begin
      half = one <<< (frac - 1);
      r    = (acc + half) >>> frac;
    end
    hi = (one <<< (dw - 1)) - one;
    lo = -hi - one;
    res.sat = 1'b0;
    if (r > hi) begin
      r       = hi;
      res.sat = 1'b1;
    end else if (r < lo) begin
      r       = lo;
      res.sat = 1'b1;
    end
    res.val = r[RES_MAX-1:0];
    return res;
  endfunction
endpackage

// File: rtl/conv2d_mac_seq_if.sv
// Window-in / result-out handshake bundle for conv2d_mac_seq.
interface conv2d_mac_seq_if #(
  parameter int DATA_WIDTH = 16,
  parameter int TAPS       = 25
);
  logic                         in_valid;
  logic                         in_ready;
  logic [TAPS*DATA_WIDTH-1:0]   window;
  logic [TAPS*DATA_WIDTH-1:0]   weights;
  logic [DATA_WIDTH-1:0]        bias;
  logic                         relu_en;
  logic                         out_valid;
  logic                         out_ready;
  logic [DATA_WIDTH-1:0]        result;
  logic                         sat;

  modport master (output in_valid, window, weights, bias, relu_en, out_ready,
                  input  in_ready, out_valid, result, sat);
  modport slave  (input  in_valid, window, weights, bias, relu_en, out_ready,
                  output in_ready, out_valid, result, sat);
endinterface

// File: rtl/conv2d_mac_seq_lane.sv
// LANES-wide signed multiply with adder tree, full-precision ACC_WIDTH sum.
// Optional output register adds one cycle of latency.
module conv_mac_lane #(
  parameter int DW        = 16,
  parameter int LANES     = 5,
  parameter int ACC_WIDTH = 40,
  parameter bit REG_OUT   = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [LANES-1:0][DW-1:0]      a,
  input  logic [LANES-1:0][DW-1:0]      b,
  output logic signed [ACC_WIDTH-1:0]   sum
);
  logic [LANES-1:0][2*DW-1:0] prod;
  logic signed [ACC_WIDTH-1:0] tree;

  always_comb begin
    prod = '0;
    tree = '0;
    for (int l = 0; l < LANES; l++) begin
      prod[l] = (2*DW)'($signed(a[l])) * (2*DW)'($signed(b[l]));
      tree    = tree + ACC_WIDTH'($signed(prod[l]));
    end
  end

  generate
    if (REG_OUT) begin : g_reg
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sum <= '0;
        else        sum <= tree;
      end
    end else begin : g_comb
      logic unused_clk;
      assign unused_clk = clk ^ rst_n;
      assign sum = tree;
    end
  endgenerate
endmodule

// File: rtl/conv2d_mac_seq.sv
// KxK window dot product with bias, accumulated LANES taps per beat,
// then rounded, saturated and optionally ReLU-clamped to DATA_WIDTH.
module conv2d_mac_seq
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int FRAC_BITS   = 7,
  parameter int KERNEL_SIZE = 5,
  parameter int LANES       = 5,
  parameter int ACC_WIDTH   = 40,
  parameter bit LANE_REG    = 1'b0
) (
  input logic              clk,
  input logic              rst_n,
  conv2d_mac_seq_if.slave  bus
);
  localparam int TAPS  = KERNEL_SIZE * KERNEL_SIZE;
  localparam int BEATS = ceil_div(TAPS, LANES);
  localparam int LAT   = LANE_REG ? 1 : 0;
  localparam int LAST  = BEATS - 1 + LAT;
  localparam int BW    = clog2(LAST + 1);
  localparam int TW    = clog2(TAPS);

  generate
    if (ACC_WIDTH < 2*DATA_WIDTH + clog2(TAPS) + 1 || ACC_WIDTH > ACC_MAX) begin : g_chk
      $error("conv2d_mac_seq: ACC_WIDTH too small for full-precision accumulation");
    end
  endgenerate

  conv_state_t state, nxt;

  logic [TAPS-1:0][DATA_WIDTH-1:0]  win_q, wt_q;
  logic                             relu_q;
  logic [BW-1:0]                    beat;
  logic signed [ACC_WIDTH-1:0]      acc;
  logic [DATA_WIDTH-1:0]            result_q;
  logic                             sat_q;

  logic [LANES-1:0][DATA_WIDTH-1:0] lane_a, lane_b;
  logic signed [ACC_WIDTH-1:0]      lane_sum;
  logic signed [ACC_MAX-1:0]        acc_ext;
  sat_res_t                         rs;
  logic                             accept, acc_en;
  logic                             unused_hi;

  assign accept = (state == IDLE) && bus.in_valid;
  // With a registered lane the first MAC cycle only primes the pipeline.
  assign acc_en = (LAT == 0) || (beat != '0);

  // Taps past the end of the kernel in a partial last beat feed zeros.
  always_comb begin
    int idx;
    idx    = 0;
    lane_a = '0;
    lane_b = '0;
    for (int l = 0; l < LANES; l++) begin
      idx = int'(beat) * LANES + l;
      if (idx < TAPS) begin
        lane_a[l] = win_q[TW'(idx)];
        lane_b[l] = wt_q[TW'(idx)];
      end
    end
  end

  conv_mac_lane #(
    .DW        (DATA_WIDTH),
    .LANES     (LANES),
    .ACC_WIDTH (ACC_WIDTH),
    .REG_OUT   (LANE_REG)
  ) u_lane (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (lane_a),
    .b     (lane_b),
    .sum   (lane_sum)
  );

  always_comb begin
    acc_ext   = {{(ACC_MAX-ACC_WIDTH){acc[ACC_WIDTH-1]}}, acc};
    rs        = sat_round(acc_ext, DATA_WIDTH, FRAC_BITS);
    unused_hi = ^rs.val[RES_MAX-1:DATA_WIDTH];
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (bus.in_valid)     nxt = MAC;
      MAC:     if (beat == BW'(LAST)) nxt = ROUND;
      ROUND:                         nxt = OUT;
      OUT:     if (bus.out_ready)    nxt = IDLE;
      default:                       nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q    <= '0;
      wt_q     <= '0;
      relu_q   <= 1'b0;
      beat     <= '0;
      acc      <= '0;
      result_q <= '0;
      sat_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          beat <= '0;
          if (accept) begin
            win_q  <= bus.window;
            wt_q   <= bus.weights;
            relu_q <= bus.relu_en;
            acc    <= {{(ACC_WIDTH-DATA_WIDTH){bus.bias[DATA_WIDTH-1]}}, bus.bias} <<< FRAC_BITS;
          end
        end
        MAC: begin
          beat <= beat + 1'b1;
          if (acc_en) acc <= acc + lane_sum;
        end
        ROUND: begin
          // ReLU zeroes the value but sat still reports clipping.
          result_q <= (relu_q && rs.val[DATA_WIDTH-1]) ? '0 : rs.val[DATA_WIDTH-1:0];
          sat_q    <= rs.sat;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == OUT);
  assign bus.result    = result_q;
  assign bus.sat       = sat_q;
endmodule

// File: tb/tb_conv2d_mac_seq.sv
// Directed checks of conv2d_mac_seq: 5x5/5-lane default plus a 3x3/4-lane instance.
module tb_conv2d_mac_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  conv2d_mac_seq_if #(.DATA_WIDTH(16), .TAPS(25)) bus5 ();
  conv2d_mac_seq_if #(.DATA_WIDTH(16), .TAPS(9))  bus3 ();

  conv2d_mac_seq dut5 (.clk(clk), .rst_n(rst_n), .bus(bus5));
  conv2d_mac_seq #(.KERNEL_SIZE(3), .LANES(4)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Integer reference: {sat, result}
  function automatic logic [16:0] model(input logic [399:0] w, input logic [399:0] k,
                                        input logic [15:0] b, input logic relu, input int taps);
    longint acc;
    logic s;
    acc = longint'($signed(b)) * 128;
    for (int i = 0; i < taps; i++)
      acc += longint'($signed(w[i*16 +: 16])) * longint'($signed(k[i*16 +: 16]));
    acc = (acc + 64) >>> 7;
    s = 1'b0;
    if (acc > 32767)       begin acc = 32767;  s = 1'b1; end
    else if (acc < -32768) begin acc = -32768; s = 1'b1; end
    if (relu && acc < 0) acc = 0;
    return {s, acc[15:0]};
  endfunction

  task automatic run5(input logic [399:0] w, input logic [399:0] k, input logic [15:0] b,
                      input logic r, output int lat);
    bus5.window = w; bus5.weights = k; bus5.bias = b; bus5.relu_en = r;
    bus5.in_valid = 1'b1;
    @(posedge clk); #1;
    bus5.in_valid = 1'b0;
    lat = 0;
    while (bus5.out_valid !== 1'b1 && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic take5();
    bus5.out_ready = 1'b1;
    @(posedge clk); #1;
    bus5.out_ready = 1'b0;
  endtask

  task automatic run3(input logic [143:0] w, input logic [143:0] k, input logic [15:0] b,
                      input logic r, output int lat, output logic [16:0] got);
    bus3.window = w; bus3.weights = k; bus3.bias = b; bus3.relu_en = r;
    bus3.in_valid = 1'b1;
    @(posedge clk); #1;
    bus3.in_valid = 1'b0;
    lat = 0;
    while (bus3.out_valid !== 1'b1 && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    got = {bus3.sat, bus3.result};
    @(posedge clk); #1;
  endtask

  initial begin
    int lat;
    logic [399:0] wv, kv;
    logic [143:0] w3, k3;
    logic [16:0] got, exp;
    logic r3, bad;

    bus5.in_valid = 0; bus5.out_ready = 0; bus5.window = '0; bus5.weights = '0;
    bus5.bias = '0; bus5.relu_en = 0;
    bus3.in_valid = 0; bus3.out_ready = 1; bus3.window = '0; bus3.weights = '0;
    bus3.bias = '0; bus3.relu_en = 0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset5", {bus5.in_ready, bus5.out_valid, bus5.sat, bus5.result}, {1'b1, 1'b0, 1'b0, 16'd0});
    chk("reset3", {bus3.in_ready, bus3.out_valid, bus3.sat, bus3.result}, {1'b1, 1'b0, 1'b0, 16'd0});
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Unity: 25 * 1.0 * 1.0 = 25.0
    run5({25{16'd128}}, {25{16'd128}}, 16'd0, 1'b0, lat);
    chk("unity_lat", lat, 6);
    chk("unity_res", {bus5.sat, bus5.result}, {1'b0, 16'd3200});
    take5();
    chk("unity_done", {bus5.in_ready, bus5.out_valid}, 2'b10);

    // Half LSB rounds up; minus half LSB rounds to zero
    wv = '0; wv[15:0] = 16'd1;
    kv = '0; kv[15:0] = 16'd64;
    run5(wv, kv, 16'd0, 1'b0, lat);
    chk("round_up", {bus5.sat, bus5.result}, {1'b0, 16'd1});
    take5();
    kv[15:0] = 16'hFFC0;
    run5(wv, kv, 16'd0, 1'b0, lat);
    chk("round_neg", {bus5.sat, bus5.result}, {1'b0, 16'd0});
    take5();

    // Bias 2.0 added to unity sum
    run5({25{16'd128}}, {25{16'd128}}, 16'd256, 1'b0, lat);
    chk("bias", {bus5.sat, bus5.result}, {1'b0, 16'd3456});
    take5();

    // Saturation both ways
    run5({25{16'h7FFF}}, {25{16'h7FFF}}, 16'd0, 1'b0, lat);
    chk("sat_pos", {bus5.sat, bus5.result}, {1'b1, 16'h7FFF});
    take5();
    run5({25{16'h7FFF}}, {25{16'h8000}}, 16'd0, 1'b0, lat);
    chk("sat_neg", {bus5.sat, bus5.result}, {1'b1, 16'h8000});
    take5();

    // ReLU on and off
    run5({25{16'd128}}, {25{16'hFF80}}, 16'd0, 1'b1, lat);
    chk("relu_on", {bus5.sat, bus5.result}, {1'b0, 16'd0});
    take5();
    run5({25{16'd128}}, {25{16'hFF80}}, 16'd0, 1'b0, lat);
    chk("relu_off", {bus5.sat, bus5.result}, {1'b0, 16'hF380});

    // Backpressure: output held, new input ignored
    bus5.window = {25{16'd1}}; bus5.weights = {25{16'd1}}; bus5.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_hold", {bus5.out_valid, bus5.in_ready, bus5.sat, bus5.result},
          {1'b1, 1'b0, 1'b0, 16'hF380});
    end
    bus5.in_valid = 1'b0;
    take5();
    chk("bp_release", {bus5.in_ready, bus5.out_valid}, 2'b10);

    // out_ready while idle does nothing
    bus5.out_ready = 1'b1;
    @(posedge clk); #1;
    bus5.out_ready = 1'b0;
    chk("idle_ready", {bus5.in_ready, bus5.out_valid}, 2'b10);

    // Reset during MAC beat 2
    bus5.window = {25{16'd128}}; bus5.weights = {25{16'd128}}; bus5.bias = '0;
    bus5.relu_en = 1'b0; bus5.in_valid = 1'b1;
    @(posedge clk); #1;
    bus5.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid", {bus5.out_valid, bus5.sat, bus5.result, bus5.in_ready},
        {1'b0, 1'b0, 16'd0, 1'b1});
    @(posedge clk); #1;
    rst_n = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus5.out_valid !== 1'b0) bad = 1'b1;
    end
    chk("no_stale", bad, 1'b0);
    run5({25{16'd128}}, {25{16'd128}}, 16'd256, 1'b0, lat);
    chk("post_rst_lat", lat, 6);
    chk("post_rst_res", {bus5.sat, bus5.result}, {1'b0, 16'd3456});
    take5();

    // 3x3 / 4 lanes: partial last beat
    for (int i = 0; i < 9; i++) w3[i*16 +: 16] = 16'((i + 1) * 128);
    k3 = {9{16'd128}};
    run3(w3, k3, 16'd0, 1'b0, lat, got);
    chk("k3_lat", lat, 4);
    chk("k3_ramp", got, {1'b0, 16'd5760});
    w3 = '0; w3[143:128] = 16'd384;
    k3 = '0; k3[143:128] = 16'hFF00;
    run3(w3, k3, 16'd128, 1'b0, lat, got);
    chk("k3_last_tap", got, {1'b0, 16'hFD80});

    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 9; i++) begin
        w3[i*16 +: 16] = 16'($urandom_range(0, 4095)) - 16'd2048;
        k3[i*16 +: 16] = 16'($urandom_range(0, 4095)) - 16'd2048;
      end
      r3 = 1'($urandom_range(0, 1));
      exp = model(400'(w3), 400'(k3), 16'd64, r3, 9);
      run3(w3, k3, 16'd64, r3, lat, got);
      chk("k3_rand", got, exp);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
